// File: rtl/int_arith_pkg.sv
// Shared definitions for the multi-word integer add/subtract datapath:
// sequencer state encoding, operation mode codes and the signed-overflow rule.
package int_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } seq_state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Signed overflow of a two's-complement add/subtract, judged from the sign
    // bits of the most significant operand words and of the result word.
    function automatic logic word_overflow(input logic mode,
                                           input logic a_msb,
                                           input logic b_msb,
                                           input logic s_msb);
        logic ovf;
        if (mode == MODE_SUB) begin
            ovf = (a_msb != b_msb) && (s_msb != a_msb);
        end else begin
            ovf = (a_msb == b_msb) && (s_msb != a_msb);
        end
        return ovf;
    endfunction

endpackage

// File: rtl/adder_subtractor.sv
// Single-word adder/subtractor. In add mode carry_in is a carry and carry_out
// the carry out of the top bit; in subtract mode both are borrows.
module adder_subtractor
    import int_arith_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  sub,
    input  logic                  carry_in,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carry_out
);

    logic [DATA_WIDTH:0] wide;

    // One extra bit captures the carry, or the borrow as a wrapped negative value.
    always_comb begin
        wide = '0;
        if (sub == MODE_SUB) begin
            wide = {1'b0, a} - {1'b0, b} - {{DATA_WIDTH{1'b0}}, carry_in};
        end else begin
            wide = {1'b0, a} + {1'b0, b} + {{DATA_WIDTH{1'b0}}, carry_in};
        end
    end

    assign result    = wide[DATA_WIDTH-1:0];
    assign carry_out = wide[DATA_WIDTH];

endmodule

// File: rtl/multiword_addsub_sequencer.sv
// Streams multi-word operands (LS word first) through one shared
// adder_subtractor, holding the inter-word carry/borrow in a register, and
// streams result words out behind a single output register.
module multiword_addsub_sequencer
    import int_arith_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_WORDS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_word,
    output logic                  out_last,
    output logic                  carry_out,
    output logic                  overflow
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    seq_state_e            state_q, state_d;
    logic                  mode_q, mode_d;
    logic                  carry_q, carry_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] out_word_q, out_word_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  carry_out_q, carry_out_d;
    logic                  overflow_q, overflow_d;

    logic [DATA_WIDTH-1:0] word_sum;
    logic                  word_carry;
    logic                  accept;
    logic                  drain;
    logic                  is_last;

    adder_subtractor #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_addsub (
        .a         (in_a),
        .b         (in_b),
        .sub       (mode_q),
        .carry_in  (carry_q),
        .result    (word_sum),
        .carry_out (word_carry)
    );

    // A new word may enter whenever the single output slot is empty or emptying.
    assign in_ready = (state_q == ST_ACTIVE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid_q && out_ready;
    assign is_last  = (idx_q == LAST_IDX);

    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign out_last  = out_last_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

    // Next-state and datapath update for the IDLE -> ACTIVE -> DRAIN sequence.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        out_word_d  = out_word_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    carry_d = 1'b0;
                    idx_d   = '0;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (drain) begin
                    out_valid_d = 1'b0;
                end
                if (accept) begin
                    out_word_d  = word_sum;
                    out_valid_d = 1'b1;
                    carry_d     = word_carry;
                    if (is_last) begin
                        // Counter stays put on the last word so it never wraps.
                        out_last_d  = 1'b1;
                        carry_out_d = word_carry;
                        overflow_d  = word_overflow(mode_q, in_a[DATA_WIDTH-1],
                                                    in_b[DATA_WIDTH-1],
                                                    word_sum[DATA_WIDTH-1]);
                        state_d     = ST_DRAIN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain && out_last_q) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter, carry and output registers; reset aborts any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_ADD;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            out_word_q  <= out_word_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_multiword_addsub_sequencer.sv
// Bench for multiword_addsub_sequencer: directed cases plus randomized
// operations checked against full-width arithmetic on 64-bit operands.
module tb_multiword_addsub_sequencer;

    localparam int W = 16;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         mode;
    logic         busy;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_word;
    logic         out_last;
    logic         carry_out;
    logic         overflow;

    int errors = 0;
    int checks = 0;

    multiword_addsub_sequencer #(
        .DATA_WIDTH (W),
        .NUM_WORDS  (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_last  (out_last),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one full operation starting at a negedge; returns at the negedge
    // after the final output handshake.
    task automatic run_op(input logic m, input logic [63:0] A, input logic [63:0] B,
                          input bit stall, input bit rnd);
        logic [64:0] u;
        logic [64:0] sx;
        logic [63:0] exp_r;
        logic        exp_c;
        logic        exp_v;
        int sent = 0;
        int rcv = 0;
        int cyc = 0;
        int stall_cnt = 0;
        bit stalling;
        bit acc;
        bit fire;

        if (m) begin
            u     = {1'b0, A} - {1'b0, B};
            exp_c = (A < B);
            sx    = {A[63], A} - {B[63], B};
        end else begin
            u     = {1'b0, A} + {1'b0, B};
            exp_c = u[64];
            sx    = {A[63], A} + {B[63], B};
        end
        exp_r = u[63:0];
        exp_v = (sx[64] != sx[63]);

        start = 1'b1;
        mode  = m;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        mode  = ~m;
        chk("busy_after_start", busy, 1'b1);

        while (rcv < N && cyc < 200) begin
            stalling  = stall && (rcv == 1) && (stall_cnt < 3);
            in_valid  = (sent < N) && (!rnd || ($urandom_range(0, 3) != 0));
            in_a      = (sent < N) ? A[16*sent +: 16] : W'($urandom);
            in_b      = (sent < N) ? B[16*sent +: 16] : W'($urandom);
            out_ready = stalling ? 1'b0 : (!rnd || ($urandom_range(0, 3) != 0));
            start     = stalling;
            mode      = ~m;
            #1;
            acc  = in_valid && in_ready;
            fire = out_valid && out_ready;
            if (stalling && out_valid) begin
                chk("stall_in_ready", in_ready, 1'b0);
                chk("stall_out_word", out_word, exp_r[16*rcv +: 16]);
                stall_cnt++;
            end
            if (fire) begin
                chk("out_word", out_word, exp_r[16*rcv +: 16]);
                chk("out_last", out_last, (rcv == N - 1));
                if (rcv == N - 1) begin
                    chk("carry_out", carry_out, exp_c);
                    chk("overflow", overflow, exp_v);
                end
                rcv++;
            end
            if (acc) sent++;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("words_received", rcv, N);
        chk("idle_after_op", busy, 1'b0);
        if (stall) chk("stall_cycles", stall_cnt, 3);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; in_valid = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b1;
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_carry_out", carry_out, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_out_word", out_word, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(1'b0, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0);
        run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0);
        run_op(1'b1, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b0, 1'b0);
        run_op(1'b1, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b0, 1'b0);
        run_op(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0);
        run_op(1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);

        // Abort an add that has built up a carry, then confirm it is gone.
        start = 1'b1; mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a = 16'hFFFF;
            in_b = (i == 0) ? 16'h0001 : 16'h0000;
            #1;
            chk("abort_in_ready", in_ready, 1'b1);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_out_word", out_word, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(1'b0, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 1'b0, 1'b0);

        // Back-to-back operations with opposite modes.
        run_op(1'b1, 64'h0000_0001_0000_0000, 64'h0000_0000_0000_0001, 1'b0, 1'b0);
        run_op(1'b0, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0);

        for (int k = 0; k < 20; k++) begin
            run_op(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                   (k % 5 == 0), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=stuck expected=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
